wm_ctrl: RTL



---
 rtl/wm_pkg.sv | 26 ++
 rtl/sec_tick_gen.sv | 38 +++
 rtl/wm_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/wm_pkg.sv
// Shared encodings for the washing-machine sequencer: state codes seen by the display
// block and the command codes produced by the key scanner.
package wm_pkg;

  localparam int unsigned SecW   = 8;
  localparam int unsigned MaxSec = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5
  } wm_state_e;

  typedef enum logic [2:0] {
    KEY_NONE      = 3'd0,
    KEY_START     = 3'd1,
    KEY_FILL      = 3'd2,
    KEY_STOP_FILL = 3'd3,
    KEY_PAUSE     = 3'd4,
    KEY_RESUME    = 3'd5
  } wm_key_e;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler: emits a single-cycle tick every TICK_DIV enabled cycles.
// Holds its count while disabled; clr restarts the second from zero.
module sec_tick_gen #(
  parameter int unsigned TICK_DIV = 20000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  // Not gated by clr: the consumer uses tick to decide whether to clear.
  assign tick = en && (cnt_q == CntMax);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wm_ctrl.sv
// Washing-machine sequencer: FILL -> WASH -> DRAIN -> SPIN -> DONE on one-second timers,
// driven by edge-detected key codes, with pause/resume and abort.
module wm_ctrl #(
  parameter int unsigned TICK_DIV  = 20000000,
  parameter int unsigned FILL_SEC  = 60,
  parameter int unsigned WASH_SEC  = 120,
  parameter int unsigned DIR_SEC   = 5,
  parameter int unsigned DRAIN_SEC = 40,
  parameter int unsigned SPIN_SEC  = 60,
  parameter int unsigned BUZZ_SEC  = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] key_value,
  output logic       valve_in,
  output logic       valve_out,
  output logic       motor_fwd,
  output logic       motor_rev,
  output logic       buzzer,
  output logic       paused,
  output logic [2:0] state,
  output logic [7:0] sec_left
);

  import wm_pkg::*;

  if (FILL_SEC > MaxSec || WASH_SEC > MaxSec || DIR_SEC > MaxSec || DRAIN_SEC > MaxSec ||
      SPIN_SEC > MaxSec || BUZZ_SEC > MaxSec || FILL_SEC == 0 || WASH_SEC == 0 ||
      DIR_SEC == 0 || DRAIN_SEC == 0 || SPIN_SEC == 0 || BUZZ_SEC == 0) begin : g_dur_check
    $error("wm_ctrl: every duration must be in 1..255 seconds");
  end

  localparam logic [SecW-1:0] DirLast = SecW'(DIR_SEC - 1);

  function automatic logic [SecW-1:0] dur_of(input wm_state_e s);
    case (s)
      ST_FILL:  return SecW'(FILL_SEC);
      ST_WASH:  return SecW'(WASH_SEC);
      ST_DRAIN: return SecW'(DRAIN_SEC);
      ST_SPIN:  return SecW'(SPIN_SEC);
      ST_DONE:  return SecW'(BUZZ_SEC);
      default:  return '0;
    endcase
  endfunction

  function automatic wm_state_e next_of(input wm_state_e s);
    case (s)
      ST_FILL:  return ST_WASH;
      ST_WASH:  return ST_DRAIN;
      ST_DRAIN: return ST_SPIN;
      ST_SPIN:  return ST_DONE;
      default:  return ST_IDLE;
    endcase
  endfunction

  wm_state_e       state_q, state_d, nxt_state;
  logic [2:0]      key_prev_q;
  logic [SecW-1:0] sec_left_q, sec_left_d;
  logic [SecW-1:0] dir_cnt_q, dir_cnt_d;
  logic            paused_q, paused_d;
  logic            dir_rev_q, dir_rev_d;
  logic            cmd_valid, cmd_hit, enter, tick;

  sec_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_sec_tick_gen (
    .CLK  (CLK),
    .RST_N(RST_N),
    .en   (!paused_q),
    .clr  (enter),
    .tick (tick)
  );

  assign cmd_valid = (key_value != key_prev_q);

  always_comb begin
    state_d    = state_q;
    sec_left_d = sec_left_q;
    paused_d   = paused_q;
    dir_cnt_d  = dir_cnt_q;
    dir_rev_d  = dir_rev_q;
    nxt_state  = state_q;
    cmd_hit    = 1'b0;
    enter      = 1'b0;

    if (cmd_valid) begin
      case (key_value)
        KEY_NONE: begin
          cmd_hit   = 1'b1;
          enter     = 1'b1;
          nxt_state = ST_IDLE;
          paused_d  = 1'b0;
        end
        KEY_START: if (!paused_q && state_q == ST_IDLE) begin
          cmd_hit   = 1'b1;
          enter     = 1'b1;
          nxt_state = ST_FILL;
        end
        KEY_FILL: if (!paused_q && state_q == ST_WASH) begin
          cmd_hit   = 1'b1;
          enter     = 1'b1;
          nxt_state = ST_FILL;
        end
        KEY_STOP_FILL: if (!paused_q && state_q == ST_FILL) begin
          cmd_hit   = 1'b1;
          enter     = 1'b1;
          nxt_state = ST_WASH;
        end
        KEY_PAUSE: if (!paused_q && state_q != ST_IDLE && state_q != ST_DONE) begin
          cmd_hit  = 1'b1;
          paused_d = 1'b1;
        end
        KEY_RESUME: if (paused_q) begin
          cmd_hit  = 1'b1;
          paused_d = 1'b0;
        end
        default: ;
      endcase
    end

    // A state-changing command overrides the tick; a pause only discards an expiry.
    if (tick && !enter && state_q != ST_IDLE) begin
      if (sec_left_q == SecW'(1)) begin
        if (!cmd_hit) begin
          enter     = 1'b1;
          nxt_state = next_of(state_q);
        end
      end else begin
        sec_left_d = sec_left_q - SecW'(1);
        if (state_q == ST_WASH) begin
          if (dir_cnt_q == DirLast) begin
            dir_cnt_d = '0;
            dir_rev_d = !dir_rev_q;
          end else begin
            dir_cnt_d = dir_cnt_q + SecW'(1);
          end
        end
      end
    end

    if (enter) begin
      state_d    = nxt_state;
      sec_left_d = dur_of(nxt_state);
      dir_cnt_d  = '0;
      dir_rev_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      key_prev_q <= 3'd0;
      sec_left_q <= '0;
      dir_cnt_q  <= '0;
      paused_q   <= 1'b0;
      dir_rev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_value;
      sec_left_q <= sec_left_d;
      dir_cnt_q  <= dir_cnt_d;
      paused_q   <= paused_d;
      dir_rev_q  <= dir_rev_d;
    end
  end

  // Actuators decode from registers only, so reset drops them in the same instant.
  always_comb begin
    valve_in  = 1'b0;
    valve_out = 1'b0;
    motor_fwd = 1'b0;
    motor_rev = 1'b0;
    buzzer    = 1'b0;
    if (!paused_q) begin
      case (state_q)
        ST_FILL:  valve_in = 1'b1;
        ST_WASH: begin
          motor_fwd = !dir_rev_q;
          motor_rev = dir_rev_q;
        end
        ST_DRAIN: valve_out = 1'b1;
        ST_SPIN: begin
          valve_out = 1'b1;
          motor_fwd = 1'b1;
        end
        ST_DONE:  buzzer = 1'b1;
        default: ;
      endcase
    end
  end

  assign paused   = paused_q;
  assign state    = state_q;
  assign sec_left = sec_left_q;

endmodule
